// File: rtl/alu64_exec_stage.sv
// 64-bit execute-stage ALU (AND/OR/ADD/SUB/PASS/NOR) with NZVC flags feeding a 2-entry output queue.
// Latency: 1 cycle; the result is written at the accepting edge and is visible at the head on the next cycle.
// Backpressure: in_ready is registered (count<2) and never depends combinationally on out_ready.
module alu64_exec_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carry,
  output logic             illegal_op
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam int         MSB     = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             n;
    logic             v;
    logic             c;
    logic             ill;
  } entry_t;

  entry_t           r_mem [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_count;
  logic             r_in_ready;

  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  entry_t           w_entry;
  entry_t           w_head;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  // SUB reuses the adder as a + ~b + 1 so carry out of the MSB means "no borrow".
  assign w_is_sub = (operation == OP_SUB);
  assign w_b_op   = w_is_sub ? ~b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};

  // Decode the operation into a complete queue entry; illegal codes leave every field 0 except illegal_op.
  always_comb begin
    w_entry = '0;
    case (operation)
      OP_AND:  w_entry.res = a & b;
      OP_OR:   w_entry.res = a | b;
      OP_ADD: begin
        w_entry.res = w_sum[WIDTH-1:0];
        w_entry.c   = w_sum[WIDTH];
        w_entry.v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_entry.res = w_sum[WIDTH-1:0];
        w_entry.c   = w_sum[WIDTH];
        w_entry.v   = (a[MSB] != b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_PASS: w_entry.res = b;
      OP_NOR:  w_entry.res = ~(a | b);
      default: w_entry.ill = 1'b1;
    endcase
    if (!w_entry.ill) begin
      w_entry.z = (w_entry.res == '0);
      w_entry.n = w_entry.res[MSB];
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign in_ready  = r_in_ready;
  assign w_push    = in_valid && r_in_ready;
  assign w_pop     = out_valid && out_ready;

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  // Queue storage, 1-bit wrapping pointers and registered in_ready; reset wins over any push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_entry;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < 2'd2);
    end
  end

  // Outputs always present the head entry, forced to 0 while the queue is empty.
  assign w_head     = out_valid ? r_mem[r_head] : '0;
  assign result     = w_head.res;
  assign zero       = w_head.z;
  assign negative   = w_head.n;
  assign overflow   = w_head.v;
  assign carry      = w_head.c;
  assign illegal_op = w_head.ill;

endmodule

// File: tb/tb_alu64_exec_stage.sv
// Randomised and directed self-checking bench for alu64_exec_stage against a queue-based reference model.
// Latency: the model pushes/pops at each rising edge and compares all outputs at the falling edge.
// Backpressure: in_valid/out_ready are driven freely; the model decides acceptance from its own occupancy.
module tb_alu64_exec_stage;

  typedef struct packed {
    logic [63:0] res;
    logic        z;
    logic        n;
    logic        v;
    logic        c;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        negative;
  logic        overflow;
  logic        carry;
  logic        illegal_op;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t mq[$];

  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

  alu64_exec_stage #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .negative(negative),
    .overflow(overflow), .carry(carry), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Reference ALU: overflow judged by whether the exact signed result fits in 64 bits.
  function automatic exp_t ref_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    exp_t                    e;
    logic [64:0]             u;
    logic signed [65:0]      s;
    e = '0;
    case (op)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: begin
        u     = {1'b0, x} + {1'b0, y};
        e.res = u[63:0];
        e.c   = u[64];
        s     = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
        e.v   = (s > SMAX) || (s < SMIN);
      end
      4'b0110: begin
        e.res = x - y;
        e.c   = (x >= y);
        s     = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
        e.v   = (s > SMAX) || (s < SMIN);
      end
      4'b0111: e.res = y;
      4'b1100: e.res = ~(x | y);
      default: e.ill = 1'b1;
    endcase
    if (!e.ill) begin
      e.z = (e.res == 64'd0);
      e.n = e.res[63];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("in_ready",  64'(in_ready),  64'(mq.size() < 2));
    chk("result",    result,         h.res);
    chk("zero",      64'(zero),      64'(h.z));
    chk("negative",  64'(negative),  64'(h.n));
    chk("overflow",  64'(overflow),  64'(h.v));
    chk("carry",     64'(carry),     64'(h.c));
    chk("illegal",   64'(illegal_op), 64'(h.ill));
  endtask

  // One clock: compare outputs, let the edge happen, mirror it in the model, return at the falling edge.
  task automatic cycle();
    logic push, pop;
    exp_t e;
    check_outputs();
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() != 0);
    e    = ref_op(operation, a, b);
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] x,
                       input logic [63:0] y, input logic ordy);
    in_valid  = v;
    operation = op;
    a         = x;
    b         = y;
    out_ready = ordy;
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'h7FFF_FFFF_FFFF_FFFF;
      3: v = 64'h8000_0000_0000_0000;
      4: v = 64'($urandom_range(0, 7));
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] ops [7];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0000};
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
    return ops[$urandom_range(0, 6)];
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    check_outputs();

    // 1: signed overflow on ADD
    drive(1'b1, 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    cycle();
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_res", result, 64'h8000_0000_0000_0000);
    chk("t1_nvcz", {60'd0, negative, overflow, carry, zero}, 64'b1100);
    cycle();

    // 2: SUB equal and SUB borrow
    drive(1'b1, 4'b0110, 64'd5, 64'd5, 1'b1);
    cycle();
    drive(1'b1, 4'b0110, 64'd0, 64'd1, 1'b1);
    chk("t2a_res", result, 64'd0);
    chk("t2a_zcv", {61'd0, zero, carry, overflow}, 64'b110);
    cycle();
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b1);
    chk("t2b_res", result, '1);
    chk("t2b_nc", {62'd0, negative, carry}, 64'b10);
    cycle();

    // 3: PASS for CBZ and an illegal code
    drive(1'b1, 4'b0111, 64'd3, 64'd0, 1'b1);
    cycle();
    drive(1'b1, 4'b1111, 64'd3, 64'd0, 1'b1);
    chk("t3_passz", {63'd0, zero}, 64'd1);
    cycle();
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b1);
    chk("t3_ill", {62'd0, illegal_op, zero}, 64'b10);
    chk("t3_illres", result, 64'd0);
    cycle();

    // 4: backpressure, third op waits until one cycle after the first pop
    drive(1'b1, 4'b0000, 64'hF0F0, 64'hFF00, 1'b0);
    cycle();
    drive(1'b1, 4'b0001, 64'hF0F0, 64'hFF00, 1'b0);
    cycle();
    drive(1'b1, 4'b1100, 64'hF0F0, 64'hFF00, 1'b0);
    chk("t4_full", 64'(in_ready), 64'd0);
    cycle();
    chk("t4_still", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cycle();
    chk("t4_res_or", result, 64'hFFF0);
    chk("t4_reopen", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    chk("t4_res_nor", result, ~64'hFFF0);
    repeat (2) cycle();

    // 5: streaming ADDs, in_ready must never drop
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'b0010, 64'(i * 100), 64'(i), 1'b1);
      cycle();
      chk("t5_rdy", 64'(in_ready), 64'd1);
      chk("t5_res", result, 64'(i * 101));
    end
    in_valid = 1'b0;
    cycle();

    // 6: reset with two entries queued
    drive(1'b1, 4'b0001, 64'd1, 64'd2, 1'b0);
    repeat (2) cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_rdy", 64'(in_ready), 64'd1);
    chk("t6_res", result, 64'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, rand_op(), rand_operand(), rand_operand(),
            $urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
